// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: next-PC arbitration, single-outstanding imem
// handshake and a one-entry output slot toward decode.
module fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [31:0]           imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic [DATA_WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        S_START,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(4);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                  pend_q, pend_d;
    logic                  kill_q, kill_d;
    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] target;

    assign target = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_d     = pend_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        imem_req_o = 1'b0;
        unique case (state_q)
            S_START: begin
                state_d = S_REQ;
                if (redirect_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = target;
                end
            end
            S_REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    // Fetch issued from the old pc is killed if any redirect arrived
                    state_d    = S_WAIT;
                    fetch_pc_d = pc_q;
                    pend_d     = 1'b0;
                    kill_d     = redirect_i | pend_q;
                    if (redirect_i) begin
                        pc_d = target;
                    end else if (pend_q) begin
                        pc_d = pend_pc_q;
                    end
                end else if (redirect_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = target;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    kill_d = 1'b1;
                    pc_d   = target;
                end
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_i) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d    = S_OUT;
                        valid_d    = 1'b1;
                        instr_d    = imem_rdata_i;
                        instr_pc_d = fetch_pc_q;
                        pc_d       = pc_q + PC_INC;
                    end
                end
            end
            S_OUT: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_START;
            pc_q       <= RESET_VECTOR;
            fetch_pc_q <= '0;
            pend_pc_q  <= '0;
            pend_q     <= 1'b0;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // A response with no outstanding fetch is dropped; note it without stopping
    always @(posedge clk) begin
        if (rst && state_q != S_WAIT) begin
            assert (!imem_rvalid_i)
            else $info("fetch_sequencer: stray imem_rvalid_i dropped");
        end
    end

    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple imem responder
// whose grant and response delays are set per scenario.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [15:0] instr_pc_o;
    logic [15:0] pc_o;

    int errs = 0;
    int checks = 0;

    int gnt_delay = 0;
    int rsp_delay = 1;
    int req_wait = 0;
    int rsp_cnt = 0;
    logic [15:0] addr_q = '0;

    fetch_sequencer #(
        .DATA_WIDTH  (16),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .pc_o         (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [15:0] a);
        if (a == 16'h0004) return 32'h0000_0013;
        return {16'hC0DE, a};
    endfunction

    // Memory model: grant after gnt_delay request cycles, respond rsp_delay later
    initial begin
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            imem_gnt_i = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i = memf(addr_q);
                end
            end
            if (imem_req_o) begin
                if (req_wait >= gnt_delay) begin
                    imem_gnt_i = 1'b1;
                    addr_q = imem_addr_o;
                    rsp_cnt = rsp_delay;
                    req_wait = 0;
                end else begin
                    req_wait++;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        #2 rst = 1'b0;
        cyc();
        checks++;
        if (imem_req_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_req got %b want 0", imem_req_o);
        end
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_valid got %b want 0", instr_valid_o);
        end
        checks++;
        if (instr_o !== 32'h0) begin
            errs++;
            $display("FAIL rst_instr got %h want 0", instr_o);
        end
        checks++;
        if (instr_pc_o !== 16'h0) begin
            errs++;
            $display("FAIL rst_ipc got %h want 0", instr_pc_o);
        end
        checks++;
        if (pc_o !== 16'h0) begin
            errs++;
            $display("FAIL rst_pc got %h want 0", pc_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic        e_req[5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] e_addr[5]  = '{16'h0, 16'h0, 16'h0, 16'h4, 16'h0};
        logic        e_val[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (imem_req_o !== e_req[k] || instr_valid_o !== e_val[k]) begin
                errs++;
                $display("FAIL seq_ctl k%0d got req=%b v=%b want req=%b v=%b",
                         k + 1, imem_req_o, instr_valid_o, e_req[k], e_val[k]);
            end
            if (e_req[k]) begin
                checks++;
                if (imem_addr_o !== e_addr[k]) begin
                    errs++;
                    $display("FAIL seq_addr k%0d got %h want %h",
                             k + 1, imem_addr_o, e_addr[k]);
                end
            end
            if (e_val[k]) begin
                checks++;
                if (instr_pc_o !== 16'h0 || instr_o !== 32'hC0DE_0000) begin
                    errs++;
                    $display("FAIL seq_out k%0d got %h@%h want c0de0000@0000",
                             k + 1, instr_o, instr_pc_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b1 || instr_o !== 32'h13 ||
                instr_pc_o !== 16'h4 || imem_req_o !== 1'b0 || pc_o !== 16'h8) begin
                errs++;
                $display("FAIL stall_hold c%0d got v=%b i=%h ipc=%h req=%b pc=%h want 1 00000013 0004 0 0008",
                         k, instr_valid_o, instr_o, instr_pc_o, imem_req_o, pc_o);
            end
        end
        stall_i = 1'b0;
    endtask

    task automatic test_redirect_wait();
        rsp_delay = 2;
        cyc();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h8) begin
            errs++;
            $display("FAIL post_stall got req=%b addr=%h want 1 0008", imem_req_o, imem_addr_o);
        end
        cyc();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0103;
        cyc();
        redirect_i = 1'b0;
        rsp_delay = 1;
        checks++;
        if (pc_o !== 16'h0100 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rw_pc got pc=%h req=%b v=%b want 0100 0 0", pc_o, imem_req_o, instr_valid_o);
        end
        cyc();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0100 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rw_next got req=%b addr=%h v=%b want 1 0100 0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        cyc();
        cyc();
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0100 || instr_o !== 32'hC0DE_0100) begin
            errs++;
            $display("FAIL rw_out got v=%b %h@%h want 1 c0de0100@0100",
                     instr_valid_o, instr_o, instr_pc_o);
        end
    endtask

    task automatic test_redirect_req();
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0010;
        stall_i = 1'b1;
        gnt_delay = 3;
        cyc();
        stall_i = 1'b0;
        redirect_pc_i = 16'h0083;
        checks++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0010) begin
            errs++;
            $display("FAIL ro_out got v=%b req=%b addr=%h want 0 1 0010",
                     instr_valid_o, imem_req_o, imem_addr_o);
        end
        cyc();
        redirect_pc_i = 16'h0041;
        checks++;
        if (imem_addr_o !== 16'h0010 || pc_o !== 16'h0010) begin
            errs++;
            $display("FAIL rr_hold1 got addr=%h pc=%h want 0010 0010", imem_addr_o, pc_o);
        end
        cyc();
        redirect_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0010) begin
            errs++;
            $display("FAIL rr_hold2 got req=%b addr=%h want 1 0010", imem_req_o, imem_addr_o);
        end
        cyc();
        gnt_delay = 0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0010) begin
            errs++;
            $display("FAIL rr_hold3 got req=%b addr=%h want 1 0010", imem_req_o, imem_addr_o);
        end
        cyc();
        checks++;
        if (imem_req_o !== 1'b0 || pc_o !== 16'h0040 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rr_grant got req=%b pc=%h v=%b want 0 0040 0",
                     imem_req_o, pc_o, instr_valid_o);
        end
        cyc();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0040 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL rr_kill got req=%b addr=%h v=%b want 1 0040 0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        cyc();
        cyc();
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0040 || instr_o !== 32'hC0DE_0040) begin
            errs++;
            $display("FAIL rr_out got v=%b %h@%h want 1 c0de0040@0040",
                     instr_valid_o, instr_o, instr_pc_o);
        end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1;
        redirect_pc_i = 16'hFFFC;
        cyc();
        redirect_i = 1'b0;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'hFFFC) begin
            errs++;
            $display("FAIL wrap_req got req=%b addr=%h want 1 fffc", imem_req_o, imem_addr_o);
        end
        cyc();
        cyc();
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'hFFFC ||
            instr_o !== 32'hC0DE_FFFC || pc_o !== 16'h0000) begin
            errs++;
            $display("FAIL wrap_out got v=%b %h@%h pc=%h want 1 c0defffc@fffc 0000",
                     instr_valid_o, instr_o, instr_pc_o, pc_o);
        end
        cyc();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
            errs++;
            $display("FAIL wrap_next got req=%b addr=%h want 1 0000", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_async_reset();
        cyc();
        cyc();
        rsp_delay = 3;
        cyc();
        cyc();
        checks++;
        if (imem_req_o !== 1'b0 || pc_o !== 16'h0004 || instr_o !== 32'hC0DE_0000) begin
            errs++;
            $display("FAIL ar_pre got req=%b pc=%h i=%h want 0 0004 c0de0000",
                     imem_req_o, pc_o, instr_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 ||
            instr_pc_o !== 16'h0 || pc_o !== 16'h0) begin
            errs++;
            $display("FAIL ar_clear got req=%b v=%b i=%h ipc=%h pc=%h want all 0",
                     imem_req_o, instr_valid_o, instr_o, instr_pc_o, pc_o);
        end
        cyc();
        rsp_delay = 1;
        rst = 1'b1;
        cyc();
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL ar_late got req=%b addr=%h v=%b want 1 0000 0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        cyc();
        checks++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL ar_wait got req=%b v=%b want 0 0", imem_req_o, instr_valid_o);
        end
        cyc();
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 16'h0 || instr_o !== 32'hC0DE_0000) begin
            errs++;
            $display("FAIL ar_first got v=%b %h@%h want 1 c0de0000@0000",
                     instr_valid_o, instr_o, instr_pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the fetch-stage program counter and sequences instruction-memory fetches.
- Arbitrates next-PC sources (reset vector, branch/jump redirect, sequential PC+4, stall hold) and runs a single-outstanding request/grant/response handshake with instruction memory.
- Presents fetched instructions to decode through a one-entry output slot that holds while decode stalls.
- Sits between the hazard unit and branch resolution (redirect inputs) and the instruction memory port.

Parameters:
- DATA_WIDTH, 16: PC and address width.
- RESET_VECTOR, 0: PC loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode cannot accept; hold output slot.
- redirect_i  in  1  single-cycle request to restart fetch at redirect_pc_i.
- redirect_pc_i  in  DATA_WIDTH  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  DATA_WIDTH  fetch address.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  response instruction.
- instr_valid_o  out  1  output slot holds a valid instruction.
- instr_o  out  32  instruction.
- instr_pc_o  out  DATA_WIDTH  PC of instr_o.
- pc_o  out  DATA_WIDTH  PC of the next fetch (current program counter).

Behaviour:
- Reset (rst=0, async):
  - state=START; pc=RESET_VECTOR; imem_req_o=0; instr_valid_o=0; instr_o=0; instr_pc_o=0; kill=0; pending=0.
  - After release, one cycle in START, then REQ.
- States:
  - START -> REQ.
  - REQ: imem_req_o=1, imem_addr_o=pc. Address and req are held stable until imem_gnt_i; on gnt -> WAIT.
  - WAIT: imem_req_o=0; on imem_rvalid_i -> OUT if the response is kept, REQ if it is killed.
  - OUT: instr_valid_o=1. If stall_i=0, the slot is consumed this cycle and the next state is REQ.
- Sequencing:
  - On a kept response: instr_o<=imem_rdata_i; instr_pc_o<=fetched address; pc<=pc+4 (modulo 2^DATA_WIDTH, wraps to 0).
  - Fetch-to-instr_valid_o latency is 1 cycle after rvalid.
  - Back-to-back throughput: one instruction per 3 cycles minimum (REQ, WAIT, OUT) with 0-wait memory.
- Redirect:
  - The target is aligned before use: low 2 bits forced to 0.
  - In START or REQ before grant: pc is not changed mid-request. Record pending=1 and pending_pc; the in-flight request is marked kill=1 once granted.
  - In REQ with gnt in the same cycle: the granted fetch has kill=1; pc<=target.
  - In WAIT: kill=1; pc<=target. The response is discarded on rvalid, then -> REQ with the new pc.
  - In OUT: instr_valid_o<=0 next cycle regardless of stall_i; pc<=target; -> REQ.
  - Coincident with rvalid: the response is discarded; no update to instr_o, instr_pc_o or pc+4.
  - Multiple redirects before resolution: the latest target wins.
  - pending is applied to pc at grant. If the current request was from the old pc, kill that fetch.
  - pending has priority over pc+4.
- Stall:
  - In OUT with stall_i=1: instr_o, instr_pc_o, pc and instr_valid_o hold. No new request is issued.
  - stall_i has no effect in REQ or WAIT.
- Protocol:
  - imem_rvalid_i outside WAIT is ignored (flag in an assertion).
  - imem_gnt_i with imem_req_o=0 is ignored.
- pc_o always equals the internal pc register.

Test Plan:
- Reset then 0-wait memory (gnt same cycle, rvalid next), no stall -> imem_addr_o sequence 0x0000, 0x0004, 0x0008; instr_valid_o pulses every 3rd cycle with the matching instr_pc_o.
- stall_i=1 for 5 cycles while in OUT holding 0x00000013 at PC 0x0004 -> outputs unchanged for 5 cycles, no imem_req_o; next address 0x0008 after release.
- redirect_i with target 0x0103 in WAIT (fetch at 0x0008 outstanding) -> response discarded, instr_valid_o stays 0, next imem_addr_o=0x0100.
- gnt delayed 3 cycles, redirect to 0x0040 during REQ at 0x0010 -> imem_addr_o stays 0x0010 until gnt, that response is killed, next fetch at 0x0040.
- pc=0xFFFC fetch kept -> pc_o wraps to 0x0000.
- rst driven low during WAIT -> asynchronous clear of all outputs; the late rvalid after release is ignored; first fetch at RESET_VECTOR.
